// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and operand-mode constants shared by the ALU and its users
package alu_pkg;
  typedef logic [4:0] alu_op_t;
  typedef logic [1:0] alu_mode_t;
  localparam alu_op_t OP_ADD    = 5'd0;
  localparam alu_op_t OP_SUB    = 5'd1;
  localparam alu_op_t OP_AND    = 5'd2;
  localparam alu_op_t OP_OR     = 5'd3;
  localparam alu_op_t OP_XOR    = 5'd4;
  localparam alu_op_t OP_SLL    = 5'd5;
  localparam alu_op_t OP_SRL    = 5'd6;
  localparam alu_op_t OP_SRA    = 5'd7;
  localparam alu_op_t OP_SLT    = 5'd8;
  localparam alu_op_t OP_SLTU   = 5'd9;
  localparam alu_op_t OP_MUL    = 5'd11;
  localparam alu_op_t OP_MULH   = 5'd12;
  localparam alu_op_t OP_MULHSU = 5'd13;
  localparam alu_op_t OP_MULHU  = 5'd14;
  localparam alu_mode_t MODE_R_TYPE = 2'b00;
  localparam alu_mode_t MODE_I_TYPE = 2'b01;
  localparam alu_mode_t MODE_AUIPC  = 2'b10;
  localparam alu_mode_t MODE_LUI    = 2'b11;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I operation unit; RV32M multiplies added when ALU_MUL_EN is defined
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_t         i_op,
  output logic [XLEN-1:0] o_result
);
  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];
`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] w_mul_ss;
  logic [2*XLEN-1:0] w_mul_su;
  logic [2*XLEN-1:0] w_mul_uu;
  // extend to double width so a plain product yields the signed/unsigned high halves
  assign w_mul_ss = {{XLEN{i_a[XLEN-1]}}, i_a} * {{XLEN{i_b[XLEN-1]}}, i_b};
  assign w_mul_su = {{XLEN{i_a[XLEN-1]}}, i_a} * {{XLEN{1'b0}}, i_b};
  assign w_mul_uu = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
`endif
  // select the operation result; unsupported codes yield zero
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:    o_result = i_a + i_b;
      OP_SUB:    o_result = i_a - i_b;
      OP_AND:    o_result = i_a & i_b;
      OP_OR:     o_result = i_a | i_b;
      OP_XOR:    o_result = i_a ^ i_b;
      OP_SLL:    o_result = i_a << w_shamt;
      OP_SRL:    o_result = i_a >> w_shamt;
      OP_SRA:    o_result = $signed(i_a) >>> w_shamt;
      OP_SLT:    o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU:   o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
`ifdef ALU_MUL_EN
      OP_MUL:    o_result = w_mul_uu[XLEN-1:0];
      OP_MULH:   o_result = w_mul_ss[2*XLEN-1:XLEN];
      OP_MULHSU: o_result = w_mul_su[2*XLEN-1:XLEN];
      OP_MULHU:  o_result = w_mul_uu[2*XLEN-1:XLEN];
`endif
      default:   o_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_top.sv
// alu_top: EX-stage ALU with operand mux, registered result and zero flag (RV32M ops under ALU_MUL_EN)
module alu_top
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] reg_1_in,
  input  logic [XLEN-1:0] reg_2_in,
  input  logic [XLEN-1:0] imm_data_in,
  input  alu_mode_t       alu_mode_select,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] alu_result_out,
  output logic            alu_zero_out
);
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] r_result;
  // pick operands by instruction class; LUI adds the immediate to zero
  always_comb begin
    w_a = alu_mode_select == MODE_AUIPC ? pc_ex : alu_mode_select == MODE_LUI ? '0 : reg_1_in;
    w_b = alu_mode_select == MODE_R_TYPE ? reg_2_in : imm_data_in;
  end
  alu_core #(.XLEN(XLEN)) u_core (
    .i_a(w_a),
    .i_b(w_b),
    .i_op(alu_op),
    .o_result(w_result)
  );
  // capture the result every cycle; reset clears any in-flight value
  always_ff @(posedge clk) begin
    if (rst) r_result <= '0;
    else r_result <= w_result;
  end
  assign alu_result_out = r_result;
  assign alu_zero_out = r_result == '0;
endmodule

// File: tb/tb_alu_top.sv
module tb_alu_top;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc_ex = '0;
  logic [31:0] reg_1_in = '0;
  logic [31:0] reg_2_in = '0;
  logic [31:0] imm_data_in = '0;
  logic [1:0] alu_mode_select = '0;
  logic [4:0] alu_op = '0;
  logic [31:0] alu_result_out;
  logic alu_zero_out;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_top dut (
    .clk(clk),
    .rst(rst),
    .pc_ex(pc_ex),
    .reg_1_in(reg_1_in),
    .reg_2_in(reg_2_in),
    .imm_data_in(imm_data_in),
    .alu_mode_select(alu_mode_select),
    .alu_op(alu_op),
    .alu_result_out(alu_result_out),
    .alu_zero_out(alu_zero_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] m, input logic [4:0] op,
                                        input logic [31:0] r1, input logic [31:0] r2,
                                        input logic [31:0] imm, input logic [31:0] pc);
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] s;
    logic [63:0] p;
    a = (m == MODE_AUIPC) ? pc : (m == MODE_LUI) ? 32'h0 : r1;
    b = (m == MODE_R_TYPE) ? r2 : imm;
    s = b[4:0];
    p = '0;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a + ~b + 32'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << s;
      OP_SRL:  return a >> s;
      OP_SRA:  return a[31] ? ~((~a) >> s) : (a >> s);
      OP_SLT:  return {31'b0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      OP_SLTU: return {31'b0, a < b};
`ifdef ALU_MUL_EN
      OP_MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
      OP_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      OP_MULHSU: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] m, input logic [4:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] exp);
    @(negedge clk);
    alu_mode_select = m;
    alu_op = op;
    reg_1_in = r1;
    reg_2_in = r2;
    imm_data_in = imm;
    pc_ex = pc;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    @(negedge clk);
    rst = 1'b1;
    alu_mode_select = MODE_R_TYPE;
    alu_op = OP_OR;
    reg_1_in = 32'hDEAD_BEEF;
    reg_2_in = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    exp = 32'h0;
    checks++;
    if (alu_result_out !== exp) begin
      errors++;
      $display("FAIL reset_result got %h want %h", alu_result_out, exp);
    end
    checks++;
    if (alu_zero_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_zero got %b want 1", alu_zero_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0] m[11] = '{MODE_R_TYPE, MODE_I_TYPE, MODE_R_TYPE, MODE_AUIPC, MODE_LUI,
                          MODE_R_TYPE, MODE_R_TYPE, MODE_R_TYPE, MODE_I_TYPE, MODE_I_TYPE, MODE_R_TYPE};
    logic [4:0] op[11] = '{OP_ADD, OP_SUB, OP_AND, OP_ADD, OP_ADD,
                           OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SRL, OP_SLL};
    logic [31:0] r1[11] = '{32'd10, 32'd10, 32'hAA, 32'h55, 32'h77, 32'd50, 32'hFFFF_FFF6,
                            32'hFFFF_FFF6, 32'h8000_0000, 32'h8000_0000, 32'h0000_0003};
    logic [31:0] r2[11] = '{32'd20, 32'h99, 32'h0F, 32'h66, 32'h88, 32'd50, 32'd5, 32'd5,
                            32'h0, 32'h0, 32'hFFFF_FFE4};
    logic [31:0] imm[11] = '{32'h1, 32'd5, 32'h3, 32'd4, 32'h1234_5000, 32'h7, 32'h9, 32'h9,
                             32'hFFFF_FFE4, 32'd4, 32'h0};
    logic [31:0] pc[11] = '{32'h40, 32'h40, 32'h40, 32'd1000, 32'h40, 32'h40, 32'h40, 32'h40,
                            32'h40, 32'h40, 32'h40};
    logic [31:0] want[11] = '{32'h1E, 32'd5, 32'h0A, 32'd1004, 32'h1234_5000, 32'h0, 32'd1, 32'd0,
                              32'hF800_0000, 32'h0800_0000, 32'h30};
    string nm[11] = '{"add_r", "sub_i", "and_r", "add_auipc", "add_lui", "sub_zero",
                      "slt", "sltu", "sra_i", "srl_i", "sll_shamt"};
    logic [31:0] exp;
    for (int i = 0; i < 11; i++) begin
      drive(m[i], op[i], r1[i], r2[i], imm[i], pc[i], want[i]);
      exp = exp_q.pop_front();
      checks++;
      if (alu_result_out !== exp) begin
        errors++;
        $display("FAIL %s result got %h want %h", nm[i], alu_result_out, exp);
      end
      checks++;
      if (alu_zero_out !== (exp == 32'h0)) begin
        errors++;
        $display("FAIL %s zero got %b want %b", nm[i], alu_zero_out, exp == 32'h0);
      end
    end
  endtask

  task automatic test_unused_ops;
    logic [4:0] op[6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd31};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_MUL_EN
      drive(MODE_R_TYPE, op[i], 32'hFFFF_FFFD, 32'h0001_0007, 32'h0, 32'h0,
            model(MODE_R_TYPE, op[i], 32'hFFFF_FFFD, 32'h0001_0007, 32'h0, 32'h0));
`else
      drive(MODE_R_TYPE, op[i], 32'hFFFF_FFFD, 32'h0001_0007, 32'h0, 32'h0, 32'h0);
`endif
      exp = exp_q.pop_front();
      checks++;
      if (alu_result_out !== exp) begin
        errors++;
        $display("FAIL op%0d result got %h want %h", op[i], alu_result_out, exp);
      end
    end
  endtask

  task automatic test_midstream_reset;
    logic [31:0] exp;
    @(negedge clk);
    alu_mode_select = MODE_R_TYPE;
    alu_op = OP_ADD;
    reg_1_in = 32'd1;
    reg_2_in = 32'd2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (alu_result_out !== 32'h0 || alu_zero_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got %h/%b want 00000000/1", alu_result_out, alu_zero_out);
    end
    rst = 1'b0;
    drive(MODE_R_TYPE, OP_ADD, 32'd3, 32'd4, 32'h0, 32'h0, 32'd7);
    exp = exp_q.pop_front();
    checks++;
    if (alu_result_out !== exp) begin
      errors++;
      $display("FAIL post_reset got %h want %h", alu_result_out, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] m;
    logic [4:0] op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      op = 5'(i % 15);
      r1 = $urandom;
      r2 = (i % 4 == 0) ? r1 : $urandom;
      imm = $urandom;
      pc = $urandom;
      drive(m, op, r1, r2, imm, pc, model(m, op, r1, r2, imm, pc));
      exp = exp_q.pop_front();
      checks++;
      if (alu_result_out !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] mode %0d op %0d got %h want %h", i, m, op, alu_result_out, exp);
      end
      checks++;
      if (alu_zero_out !== (exp == 32'h0)) begin
        errors++;
        $display("FAIL b2b_zero[%0d] got %b want %b", i, alu_zero_out, exp == 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_unused_ops();
    test_midstream_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
